// File: rtl/yalu_pipe.sv
// yalu_pipe: two-stage pipelined ALU (AND, OR, ADD, SUB, SLT) with valid/ready
// handshakes on both sides, zero/carry/illegal-op flags and a counter of
// delivered results. Stage 1 captures operands, stage 2 computes and holds the
// result until the consumer takes it.
// Optional feature: define YALU_OVF_EN to build the signed-overflow output;
// without it ovf is tied low (SLT still uses overflow internally).
module yalu_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err,
  output logic [CNT_W-1:0] count
);

  localparam logic [2:0]       OP_AND  = 3'b000;
  localparam logic [2:0]       OP_OR   = 3'b001;
  localparam logic [2:0]       OP_ADD  = 3'b010;
  localparam logic [2:0]       OP_SUB  = 3'b110;
  localparam logic [2:0]       OP_SLT  = 3'b111;
  localparam logic [WIDTH:0]   ONE_W   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s1Valid_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [2:0]       opCode_q;

  logic             outValid_q;
  logic [WIDTH-1:0] z_q, z_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             s2Load;
  logic             inFire;
  logic             outFire;
  logic [WIDTH:0]   sumFull;
  logic [WIDTH:0]   diffFull;
  logic             ovfSub;
  logic             lt;

  // Stage 2 may take a new beat whenever it is empty or being drained;
  // stage 1 can accept when it is empty or handing its beat to stage 2.
  assign s2Load   = !outValid_q || out_ready;
  assign in_ready = !s1Valid_q || s2Load;
  assign inFire   = in_valid && in_ready;
  assign outFire  = outValid_q && out_ready;

  // Carry-out is taken from a WIDTH+1 bit sum; subtraction is a + ~b + 1.
  assign sumFull  = {1'b0, opA_q} + {1'b0, opB_q};
  assign diffFull = {1'b0, opA_q} + {1'b0, ~opB_q} + ONE_W;
  assign ovfSub   = (opA_q[WIDTH-1] != opB_q[WIDTH-1]) &&
                    (diffFull[WIDTH-1] != opA_q[WIDTH-1]);
  assign lt       = diffFull[WIDTH-1] ^ ovfSub;

  // Stage 2 result and flags computed from the stage 1 registers.
  always_comb begin
    z_d     = '0;
    carry_d = 1'b0;
    err_d   = 1'b0;
    case (opCode_q)
      OP_AND: z_d = opA_q & opB_q;
      OP_OR:  z_d = opA_q | opB_q;
      OP_ADD: begin
        z_d     = sumFull[WIDTH-1:0];
        carry_d = sumFull[WIDTH];
      end
      OP_SUB: begin
        z_d     = diffFull[WIDTH-1:0];
        carry_d = diffFull[WIDTH];
      end
      OP_SLT: begin
        z_d     = {{(WIDTH-1){1'b0}}, lt};
        carry_d = diffFull[WIDTH];
      end
      default: err_d = 1'b1;
    endcase
    zero_d = (z_d == '0);
  end

  // Delivered-result counter advances on every output handshake and wraps.
  always_comb begin
    count_d = count_q;
    if (outFire) count_d = count_q + ONE_CNT;
  end

  // Stage 1: operand capture on input handshake, valid bit tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid_q <= 1'b0;
    end else if (in_ready) begin
      s1Valid_q <= in_valid;
    end
    if (inFire && !reset) begin
      opA_q    <= a;
      opB_q    <= b;
      opCode_q <= op;
    end
  end

  // Stage 2: result register, holds exactly while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q <= 1'b0;
      z_q        <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      count_q <= count_d;
      if (s2Load) begin
        outValid_q <= s1Valid_q;
        if (s1Valid_q) begin
          z_q     <= z_d;
          zero_q  <= zero_d;
          carry_q <= carry_d;
          err_q   <= err_d;
        end
      end
    end
  end

`ifdef YALU_OVF_EN
  logic ovfAdd;
  logic ovf_q, ovf_d;

  assign ovfAdd = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) &&
                  (sumFull[WIDTH-1] != opA_q[WIDTH-1]);

  // Signed overflow is only meaningful for ADD and SUB.
  always_comb begin
    ovf_d = 1'b0;
    if (opCode_q == OP_ADD) ovf_d = ovfAdd;
    else if (opCode_q == OP_SUB) ovf_d = ovfSub;
  end

  // Overflow flag register, loaded alongside the other stage 2 flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (s2Load && s1Valid_q) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign out_valid = outValid_q;
  assign z         = z_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_yalu_pipe.sv
// tb_yalu_pipe: directed self-checking bench for yalu_pipe (WIDTH=32).
// Expected values are hand-computed; ovf expectations follow YALU_OVF_EN.
module tb_yalu_pipe;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;
`ifdef YALU_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             err;
  logic [CNT_W-1:0] count;

  int total = 0;
  int bad   = 0;

  yalu_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .zero(zero), .carry(carry), .ovf(ovf), .err(err),
    .count(count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if the sequence stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] o,
                               input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    in_valid = v;
    op       = o;
    a        = av;
    b        = bv;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 3'b000, '0, '0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({out_valid, zero, carry, ovf, err} !== 5'b0 || z !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outs: got v%b zr%b c%b o%b e%b z=%h want all 0", out_valid, zero, carry, ovf, err, z);
    end
    total++;
    if (count !== 16'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_cnt_rdy: got count=%0d in_ready=%b want 0/1", count, in_ready);
    end
  endtask

  task automatic test_add;
    applyStimulus(1'b1, 3'b010, 32'd5, 32'd7);
    tick();
    applyStimulus(1'b0, 3'b000, '0, '0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL add_latency1: got out_valid=%b want 0", out_valid);
    end
    tick();
    total++;
    if ({out_valid, zero, carry, err} !== 4'b1000 || z !== 32'd12) begin
      bad++;
      $display("[TB] FAIL add_result: got v%b zr%b c%b e%b z=%h want v1 zr0 c0 e0 z=0000000c", out_valid, zero, carry, err, z);
    end
    tick();
    total++;
    if (count !== 16'd1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL add_count: got count=%0d v=%b want 1/0", count, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]       ops [4];
    logic [WIDTH-1:0] av  [4];
    logic [WIDTH-1:0] bv  [4];
    logic [WIDTH-1:0] ez  [4];
    logic [2:0]       ef  [4];
    ops[0] = 3'b110; av[0] = 32'h1234ABCD; bv[0] = 32'h1234ABCD; ez[0] = 32'h0;        ef[0] = 3'b110;
    ops[1] = 3'b000; av[1] = 32'hF0F01234; bv[1] = 32'h0FF0FF00; ez[1] = 32'h00F01200; ef[1] = 3'b000;
    ops[2] = 3'b001; av[2] = 32'hF0F01234; bv[2] = 32'h0FF0FF00; ez[2] = 32'hFFF0FF34; ef[2] = 3'b000;
    ops[3] = 3'b111; av[3] = 32'hFFFFFFFF; bv[3] = 32'h00000001; ez[3] = 32'h1;        ef[3] = 3'b010;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        applyStimulus(1'b1, ops[i], av[i], bv[i]);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("[TB] FAIL b2b_in_ready%0d: got %b want 1", i, in_ready);
        end
      end else begin
        applyStimulus(1'b0, 3'b000, '0, '0);
      end
      tick();
      if (i >= 1 && i <= 4) begin
        total++;
        if (out_valid !== 1'b1 || z !== ez[i-1] || {zero, carry, err} !== ef[i-1] || ovf !== 1'b0) begin
          bad++;
          $display("[TB] FAIL b2b_beat%0d: got v%b z=%h zr/c/e=%b o%b want v1 z=%h zr/c/e=%b o0", i-1, out_valid, z, {zero, carry, err}, ovf, ez[i-1], ef[i-1]);
        end
      end
    end
    total++;
    if (count !== 16'd5 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_count: got count=%0d v=%b want 5/0", count, out_valid);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'b010, 32'd1, 32'd1);
    tick();
    applyStimulus(1'b1, 3'b010, 32'd2, 32'd2);
    tick();
    applyStimulus(1'b1, 3'b010, 32'd3, 32'd3);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || z !== 32'd2) begin
        bad++;
        $display("[TB] FAIL stall%0d: got in_ready=%b v=%b z=%h want 0/1/00000002", i, in_ready, out_valid, z);
      end
      tick();
    end
    applyStimulus(1'b0, 3'b000, '0, '0);
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b1 || z !== 32'd4 || count !== 16'd6) begin
      bad++;
      $display("[TB] FAIL drain1: got v=%b z=%h count=%0d want 1/00000004/6", out_valid, z, count);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || count !== 16'd7) begin
      bad++;
      $display("[TB] FAIL drain2: got v=%b count=%0d want 0/7", out_valid, count);
    end
  endtask

  task automatic test_illegal;
    out_ready = 1'b1;
    applyStimulus(1'b1, 3'b011, 32'd3, 32'd4);
    tick();
    applyStimulus(1'b0, 3'b000, '0, '0);
    tick();
    total++;
    if ({out_valid, zero, carry, ovf, err} !== 5'b11001 || z !== '0) begin
      bad++;
      $display("[TB] FAIL illegal: got v%b zr%b c%b o%b e%b z=%h want v1 zr1 c0 o0 e1 z=0", out_valid, zero, carry, ovf, err, z);
    end
    tick();
    total++;
    if (count !== 16'd8) begin
      bad++;
      $display("[TB] FAIL illegal_count: got %0d want 8", count);
    end
  endtask

  task automatic test_overflow;
    out_ready = 1'b1;
    applyStimulus(1'b1, 3'b010, 32'h7FFFFFFF, 32'h00000001);
    tick();
    applyStimulus(1'b1, 3'b111, 32'h80000000, 32'h00000001);
    tick();
    applyStimulus(1'b0, 3'b000, '0, '0);
    total++;
    if (out_valid !== 1'b1 || z !== 32'h80000000 || ovf !== OVF_ON || {zero, carry, err} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL ovf_add: got v%b z=%h o%b zr/c/e=%b want v1 z=80000000 o%b zr/c/e=000", out_valid, z, ovf, {zero, carry, err}, OVF_ON);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || z !== 32'h1 || ovf !== 1'b0 || {zero, carry, err} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL ovf_slt: got v%b z=%h o%b zr/c/e=%b want v1 z=00000001 o0 zr/c/e=010", out_valid, z, ovf, {zero, carry, err});
    end
    tick();
    total++;
    if (count !== 16'd10) begin
      bad++;
      $display("[TB] FAIL ovf_count: got %0d want 10", count);
    end
  endtask

  task automatic test_reset_full;
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'b010, 32'd10, 32'd10);
    tick();
    applyStimulus(1'b1, 3'b010, 32'd11, 32'd11);
    tick();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || z !== 32'd20) begin
      bad++;
      $display("[TB] FAIL full_before_reset: got in_ready=%b v=%b z=%h want 0/1/00000014", in_ready, out_valid, z);
    end
    applyStimulus(1'b1, 3'b010, 32'd99, 32'd99);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 3'b000, '0, '0);
    out_ready = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || count !== 16'd0 || in_ready !== 1'b1 || z !== '0) begin
      bad++;
      $display("[TB] FAIL reset_full: got v=%b count=%0d in_ready=%b z=%h want 0/0/1/0", out_valid, count, in_ready, z);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || count !== 16'd0) begin
        bad++;
        $display("[TB] FAIL reset_flush%0d: got v=%b count=%0d want 0/0", i, out_valid, count);
      end
    end
  endtask

  // Main sequence: each scenario task drives and checks on its own.
  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    applyStimulus(1'b0, 3'b000, '0, '0);
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_overflow();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
